// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the convolution frame sequencer.
`default_nettype none

package conv_ctrl_pkg;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  localparam logic [1:0] MODE_GREY = 2'b00;
  localparam logic [1:0] MODE_VERT = 2'b01;
  localparam logic [1:0] MODE_HORZ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DRAIN  = 2'd3
  } seq_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_pos_counter.sv
// Column/row position tracker for the pixel stream; clear restarts the frame
// and may coincide with advance so the restarting pixel counts as position 0.
`default_nettype none

module conv_pos_counter
  import conv_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          advance,
  output logic [cnt_bits(WIDTH)-1:0]    col,
  output logic [cnt_bits(HEIGHT)-1:0]   row,
  output logic                          last
);

  localparam int CW = cnt_bits(WIDTH);
  localparam int RW = cnt_bits(HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  logic [CW-1:0] col_base;
  logic [RW-1:0] row_base;

  always_comb begin
    col_base = clear ? '0 : col;
    row_base = clear ? '0 : row;
  end

  assign last = (col == COL_MAX) && (row == ROW_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_base == COL_MAX) begin
        col <= '0;
        row <= (row_base == ROW_MAX) ? '0 : row_base + 1'b1;
      end else begin
        col <= col_base + 1'b1;
        row <= row_base;
      end
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer feeding a convolution line buffer: forwards one camera frame,
// flushes the buffer with zero pixels, drains, then signals frame completion.
`default_nettype none

module conv_frame_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int FLUSH_PIX = 642,
  parameter int DRAIN_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] cam_red,
  input  logic [11:0] cam_green,
  input  logic [11:0] cam_blue,
  input  logic        cam_dval,
  input  logic        cam_sof,
  input  logic [1:0]  mode_req,
  input  logic        mode_wr,
  input  logic        err_clr,
  output logic [11:0] ired,
  output logic [11:0] igreen,
  output logic [11:0] iblue,
  output logic        idval,
  output logic [1:0]  mode,
  input  logic        odval,
  output logic [18:0] out_cnt,
  output logic        busy,
  output logic        frame_done,
  output logic        err_sync,
  output logic        err_overrun
);

  localparam int FW = cnt_bits(FLUSH_PIX);
  localparam int DW = cnt_bits(DRAIN_CYC);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_PIX - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [18:0]   OUT_MAX    = '1;

  seq_state_t                  state;
  logic [FW-1:0]               flush_cnt;
  logic                        flush_phase;
  logic [DW-1:0]               drain_cnt;
  logic [1:0]                  mode_pend;
  logic [cnt_bits(WIDTH)-1:0]  col;
  logic [cnt_bits(HEIGHT)-1:0] row;
  logic                        last;
  logic                        sof_hit;
  logic                        pos_advance;
  logic                        pos_unused;

  always_comb begin
    sof_hit     = cam_dval && cam_sof && (state == ST_IDLE || state == ST_STREAM);
    pos_advance = sof_hit || (cam_dval && state == ST_STREAM);
  end

  // Only the end-of-frame flag drives sequencing; position is kept for visibility.
  assign pos_unused = ^{col, row};

  conv_pos_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (sof_hit),
    .advance (pos_advance),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ired        <= '0;
      igreen      <= '0;
      iblue       <= '0;
      idval       <= 1'b0;
      mode        <= MODE_GREY;
      mode_pend   <= MODE_GREY;
      out_cnt     <= '0;
      frame_done  <= 1'b0;
      err_sync    <= 1'b0;
      err_overrun <= 1'b0;
      flush_cnt   <= '0;
      flush_phase <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      idval      <= 1'b0;
      ired       <= '0;
      igreen     <= '0;
      iblue      <= '0;
      frame_done <= 1'b0;

      if (mode_wr) mode_pend <= mode_req;
      // Sticky flags: a set later in this block overrides the clear.
      if (err_clr) begin
        err_sync    <= 1'b0;
        err_overrun <= 1'b0;
      end
      if (state != ST_IDLE && odval && out_cnt != OUT_MAX) out_cnt <= out_cnt + 19'd1;

      case (state)
        ST_IDLE: begin
          if (sof_hit) begin
            idval   <= 1'b1;
            ired    <= cam_red;
            igreen  <= cam_green;
            iblue   <= cam_blue;
            mode    <= mode_wr ? mode_req : mode_pend;
            out_cnt <= '0;
            state   <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (cam_dval) begin
            idval  <= 1'b1;
            ired   <= cam_red;
            igreen <= cam_green;
            iblue  <= cam_blue;
            if (cam_sof) begin
              err_sync <= 1'b1;
              mode     <= mode_wr ? mode_req : mode_pend;
              out_cnt  <= '0;
            end else if (last) begin
              state       <= ST_FLUSH;
              flush_cnt   <= '0;
              flush_phase <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          flush_phase <= ~flush_phase;
          if (!flush_phase) begin
            idval <= 1'b1;
            if (flush_cnt == FLUSH_LAST) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if ((state == ST_FLUSH || state == ST_DRAIN) && cam_dval) err_overrun <= 1'b1;
    end
  end

endmodule

`default_nettype wire
